// File: rtl/seq_shifter.sv
// seq_shifter: multicycle shifter with valid/ready handshakes on both sides.
// Supports logical-right, arithmetic-right, logical-left and rotate-right
// shifts, moving at most STEP bit positions per clock.
//
// Optional build macro: SEQ_SHIFTER_STATUS_EN adds the zero/sticky outputs.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | in_ready high, waiting for in_valid
// RUN   | shifting the working register, remain positions left to go
// DONE  | result on d with out_valid high, waiting for out_ready
module seq_shifter #(
    parameter int DATAWIDTH = 8,
    parameter int STEP      = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] sh_amt,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] d
`ifdef SEQ_SHIFTER_STATUS_EN
    ,
    output logic                 zero,
    output logic                 sticky
`endif
);

    // Count width holds 0..DATAWIDTH inclusive (saturated amount).
    localparam int CW = $clog2(DATAWIDTH) + 1;

    localparam logic [CW-1:0]        DW_CNT   = CW'(DATAWIDTH);
    localparam logic [DATAWIDTH-1:0] DW_VAL   = DATAWIDTH'(DATAWIDTH);
    localparam logic [CW-1:0]        STEP_CNT = CW'(STEP);
    localparam logic [DATAWIDTH-1:0] ONES     = '1;

    localparam logic [1:0] M_LSR = 2'b00;
    localparam logic [1:0] M_ASR = 2'b01;
    localparam logic [1:0] M_LSL = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t                 state;
    logic [DATAWIDTH-1:0]   work;
    logic [CW-1:0]          remain;
    logic [1:0]             mode_q;
    logic                   sign_q;

    logic [CW-1:0]          eff_amt;
    logic [CW-1:0]          k;
    logic [DATAWIDTH-1:0]   lo_mask;
    logic [DATAWIDTH-1:0]   hi_mask;
    logic [DATAWIDTH-1:0]   step_val;

`ifdef SEQ_SHIFTER_STATUS_EN
    logic                   sticky_acc;
    logic                   lost;
`endif

    // Ready only in IDLE; forced low while reset is held so a request
    // cannot be presented against a block that is being cleared.
    assign in_ready = Rst && (state == S_IDLE);

    // Effective shift amount: rotate wraps, the others saturate at DATAWIDTH.
    always_comb begin
        eff_amt = '0;
        if (mode == M_ROR) begin
            eff_amt = {1'b0, sh_amt[CW-2:0]};
        end else if (sh_amt >= DW_VAL) begin
            eff_amt = DW_CNT;
        end else begin
            eff_amt = sh_amt[CW-1:0];
        end
    end

    // Positions moved this RUN cycle: the full STEP, or whatever is left.
    always_comb begin
        k = (remain > STEP_CNT) ? STEP_CNT : remain;
    end

    // One RUN step of the working register by k positions.
    always_comb begin
        lo_mask  = ~(ONES << k);
        hi_mask  = ~(ONES >> k);
        step_val = work;
        case (mode_q)
            M_LSR:   step_val = work >> k;
            M_ASR:   step_val = (work >> k) | (hi_mask & {DATAWIDTH{sign_q}});
            M_LSL:   step_val = work << k;
            default: step_val = (work >> k) | (work << (DW_CNT - k));
        endcase
    end

`ifdef SEQ_SHIFTER_STATUS_EN
    // Any 1 pushed off the end during this step (rotate loses nothing).
    always_comb begin
        lost = 1'b0;
        case (mode_q)
            M_LSR:   lost = |(work & lo_mask);
            M_ASR:   lost = |(work & lo_mask);
            M_LSL:   lost = |(work & hi_mask);
            default: lost = 1'b0;
        endcase
    end
`endif

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= S_IDLE;
            work       <= '0;
            remain     <= '0;
            mode_q     <= '0;
            sign_q     <= 1'b0;
            out_valid  <= 1'b0;
            d          <= '0;
`ifdef SEQ_SHIFTER_STATUS_EN
            sticky_acc <= 1'b0;
            zero       <= 1'b0;
            sticky     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mode_q     <= mode;
                        sign_q     <= a[DATAWIDTH-1];
                        work       <= a;
                        remain     <= eff_amt;
`ifdef SEQ_SHIFTER_STATUS_EN
                        sticky_acc <= 1'b0;
                        sticky     <= 1'b0;
                        zero       <= 1'b0;
`endif
                        if (eff_amt == '0) begin
                            d         <= a;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
`ifdef SEQ_SHIFTER_STATUS_EN
                            zero      <= (a == '0);
`endif
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    work       <= step_val;
                    remain     <= remain - k;
`ifdef SEQ_SHIFTER_STATUS_EN
                    sticky_acc <= sticky_acc | lost;
`endif
                    if (remain == k) begin
                        d         <= step_val;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
`ifdef SEQ_SHIFTER_STATUS_EN
                        zero      <= (step_val == '0);
                        sticky    <= sticky_acc | lost;
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // The unused encoding must never be reached.
    a_state_legal: assert property (@(posedge Clk) disable iff (!Rst)
        state != 2'b11);

    // out_valid is high exactly while the result is being offered.
    a_valid_done: assert property (@(posedge Clk) disable iff (!Rst)
        out_valid == (state == S_DONE));

    // RUN always has work left to do.
    a_run_nonzero: assert property (@(posedge Clk) disable iff (!Rst)
        (state == S_RUN) |-> (remain != '0));
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Randomised and directed bench for seq_shifter (DATAWIDTH=8, STEP=2).
module tb_seq_shifter;

    localparam int W  = 8;
    localparam int ST = 2;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] sh_amt = '0;
    logic [1:0]   mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] d;
`ifdef SEQ_SHIFTER_STATUS_EN
    logic         zero;
    logic         sticky;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    seq_shifter #(.DATAWIDTH(W), .STEP(ST)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .sh_amt    (sh_amt),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d)
`ifdef SEQ_SHIFTER_STATUS_EN
        ,
        .zero      (zero),
        .sticky    (sticky)
`endif
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the shift rules, no stepping.
    task automatic ref_model(input int av, input int amt, input int md,
                             output int dv, output int stk, output int zr,
                             output int lat);
        int n;
        int sx;
        if (md == 3) n = amt % W;
        else         n = (amt > W) ? W : amt;
        case (md)
            0: dv = av >> n;
            1: begin
                sx = (av >= 128) ? av - 256 : av;
                dv = (sx >>> n) & 255;
            end
            2: dv = (av << n) & 255;
            default: dv = (((av << W) | av) >> n) & 255;
        endcase
        if (md == 3)      stk = 0;
        else if (md == 2) stk = ((av >> (W - n)) != 0) ? 1 : 0;
        else              stk = ((av & ((1 << n) - 1)) != 0) ? 1 : 0;
        zr  = (dv == 0) ? 1 : 0;
        lat = (n + ST - 1) / ST + 1;
    endtask

    // One full transaction: request, wait for result, hold, handshake out.
    task automatic run_op(input int ta, input int tamt, input int tm, input int hold);
        int edv, est, ezr, elat, lat, g;
        ref_model(ta, tamt, tm, edv, est, ezr, elat);
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge Clk); #1;
            g++;
        end
        check_val("in_ready_idle", in_ready, 1);
        a        = W'(ta);
        sh_amt   = W'(tamt);
        mode     = 2'(tm);
        in_valid = 1'b1;
        @(posedge Clk); #1;
        // Inputs after acceptance must have no effect.
        in_valid = 1'($urandom_range(0, 1));
        a        = W'($urandom);
        sh_amt   = W'($urandom);
        mode     = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge Clk); #1;
            lat++;
        end
        check_val($sformatf("latency a=%0h amt=%0d m=%0d", ta, tamt, tm), lat, elat);
        check_val($sformatf("d a=%0h amt=%0d m=%0d", ta, tamt, tm), d, edv);
`ifdef SEQ_SHIFTER_STATUS_EN
        check_val("zero", zero, ezr);
        check_val("sticky", sticky, est);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            @(posedge Clk); #1;
            check_val("hold_out_valid", out_valid, 1);
            check_val("hold_d", d, edv);
            check_val("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        check_val("post_hs_out_valid", out_valid, 0);
        check_val("post_hs_in_ready", in_ready, 1);
        check_val("post_hs_d_kept", d, edv);
    endtask

    initial begin
        #3;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_d", d, 0);
        check_val("rst_in_ready", in_ready, 0);
        #9 Rst = 1'b1;
        @(posedge Clk); #1;
        check_val("post_rst_in_ready", in_ready, 1);
        check_val("post_rst_out_valid", out_valid, 0);

        // Directed cases from the shift rules.
        run_op(8'hB4, 2, 1, 0);
        run_op(8'hB4, 2, 0, 0);
        run_op(8'hB4, 3, 3, 0);
        run_op(8'hB4, 3, 2, 0);
        run_op(8'h80, 200, 1, 0);
        run_op(8'h80, 200, 0, 0);
        run_op(8'h80, 11, 3, 0);
        for (int m = 0; m < 4; m++) run_op(8'h5A, 0, m, 0);
        run_op(8'hC3, 5, 1, 4);
        run_op(8'h00, 8, 1, 0);
        run_op(8'hFF, 8, 2, 1);

        // Random transactions, amounts biased towards the interesting range.
        for (int i = 0; i < 60; i++) begin
            int amt;
            if ($urandom_range(0, 3) == 0) amt = $urandom_range(0, 255);
            else                           amt = $urandom_range(0, 10);
            run_op($urandom_range(0, 255), amt, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of RUN, with a nonzero d beforehand.
        run_op(8'h5A, 0, 0, 0);
        a        = 8'hFF;
        sh_amt   = 8'd8;
        mode     = 2'b00;
        in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        @(posedge Clk); #1;
        #2 Rst = 1'b0;
        #1;
        check_val("midrun_rst_out_valid", out_valid, 0);
        check_val("midrun_rst_d", d, 0);
        check_val("midrun_rst_in_ready", in_ready, 0);
        #3 Rst = 1'b1;
        @(posedge Clk); #1;
        check_val("rel_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            check_val("no_stale_out_valid", out_valid, 0);
        end
        run_op(8'h96, 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #500000;
        n_errors++;
        $display("FAIL timeout: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
